// File: rtl/parking_lane_counter.sv
// ============================================================================
// parking_lane_counter
//
// Multi-lane parking-lot access controller. Every lane watches a two-beam
// sensor pair {a, b}: a is the outer beam (street side), b the inner beam
// (lot side). A car driving in blocks a, then both, then only b, then
// neither. A car driving out produces the mirror sequence. Each lane
// synchronises and debounces its pair, then a small FSM turns complete
// passes into entry/exit pulses and flags sequences that make no physical
// sense. A shared saturating occupancy counter collects the pulses from
// all lanes.
//
// Parameters
//   LANES      number of independent sensor lanes (>= 1)
//   CAP        lot capacity, the maximum occupancy (>= 1)
//   DEB        debounce length in cycles (>= 1)
//   CNT_W      occupancy width, $clog2(CAP+1) (derived)
//
// Ports
//   clk        in   1          system clock
//   reset      in   1          asynchronous, active-high reset
//   sensor     in   2*LANES    raw beams, lane i: [2i+1] = a, [2i] = b, 1 = blocked
//   occ_load   in   1          synchronous load of the occupancy counter
//   occ_value  in   CNT_W      load value, clamped to CAP
//   lane_in    out  LANES      one-cycle entry pulse per lane
//   lane_out   out  LANES      one-cycle exit pulse per lane
//   lane_err   out  LANES      one-cycle invalid-sequence pulse per lane
//   occupancy  out  CNT_W      current car count, 0..CAP
//   full       out  1          occupancy == CAP
//   empty      out  1          occupancy == 0
//   ovf        out  1          one-cycle pulse: entries clamped at CAP
//   udf        out  1          one-cycle pulse: exits clamped at 0
// ============================================================================
module parking_lane_counter #(
    parameter int  LANES = 2,
    parameter int  CAP   = 64,
    parameter int  DEB   = 4,
    localparam int CNT_W = $clog2(CAP + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2*LANES-1:0] sensor,
    input  logic               occ_load,
    input  logic [CNT_W-1:0]   occ_value,
    output logic [LANES-1:0]   lane_in,
    output logic [LANES-1:0]   lane_out,
    output logic [LANES-1:0]   lane_err,
    output logic [CNT_W-1:0]   occupancy,
    output logic               full,
    output logic               empty,
    output logic               ovf,
    output logic               udf
);

    // ------------------------------------------------------------------
    // Local sizing
    // ------------------------------------------------------------------
    // Debounce counter saturates at DEB, so it needs to hold 0..DEB.
    localparam int DEB_CW = $clog2(DEB + 1);

    // The per-cycle net change lies in -LANES..+LANES and the sum
    // occupancy + net in -LANES..CAP+LANES. One extra magnitude bit over
    // the wider of the two operands plus a sign bit covers both.
    localparam int LANE_W = $clog2(LANES + 1);
    localparam int NET_W  = ((CNT_W > LANE_W) ? CNT_W : LANE_W) + 2;

    localparam logic signed [NET_W-1:0] CAP_S   = NET_W'(CAP);
    localparam logic        [CNT_W-1:0] CAP_CNT = CNT_W'(CAP);
    localparam logic       [DEB_CW-1:0] DEB_CNT = DEB_CW'(DEB);

    // Beam-pair encoding used throughout: {a, b}.
    localparam logic [1:0] P_NONE  = 2'b00;
    localparam logic [1:0] P_INNER = 2'b01;
    localparam logic [1:0] P_OUTER = 2'b10;
    localparam logic [1:0] P_BOTH  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IN1,    // outer beam only, car coming in
        S_IN2,    // both beams, car coming in
        S_IN3,    // inner beam only, car coming in
        S_OUT1,   // inner beam only, car going out
        S_OUT2,   // both beams, car going out
        S_OUT3,   // outer beam only, car going out
        S_WAIT    // sequence broken, wait for a clear lane
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser: two flops on the whole raw bus. Each lane only
    // ever looks at its own pair, so there is no cross-bit coherence issue
    // beyond what the debouncer already absorbs.
    // ------------------------------------------------------------------
    logic [2*LANES-1:0] sync1;
    logic [2*LANES-1:0] sync2;

    // NOTE: every clocked register below is written with non-blocking
    // assignments so all flops sample pre-edge values regardless of the
    // order the statements appear in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sensor;
            sync2 <= sync1;
        end
    end

    // ------------------------------------------------------------------
    // Debouncer, one per lane.
    //
    // cand holds the last synchronised pair and cnt how many consecutive
    // cycles the synchronised pair has matched it (the first cycle of a
    // new value counts as 1). filt follows cand on the cycle the run
    // length reaches DEB. Any change restarts the run at 1, so a glitch
    // shorter than DEB cycles never makes it to filt.
    // ------------------------------------------------------------------
    logic [1:0]        cand     [LANES];
    logic [DEB_CW-1:0] cnt      [LANES];
    logic [DEB_CW-1:0] cnt_next [LANES];
    logic [1:0]        filt     [LANES];

    // NOTE: combinational outputs get an unconditional default before any
    // branch, so no path leaves them unassigned and no latch is inferred.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            cnt_next[i] = cnt[i];
            if (sync2[2*i +: 2] != cand[i]) begin
                cnt_next[i] = DEB_CW'(1);
            end else if (cnt[i] < DEB_CNT) begin
                cnt_next[i] = cnt[i] + DEB_CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                cand[i] <= P_NONE;
                cnt[i]  <= '0;
                filt[i] <= P_NONE;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                cand[i] <= sync2[2*i +: 2];
                cnt[i]  <= cnt_next[i];
                // Once saturated, cand equals the synchronised value, so
                // re-loading filt every stable cycle is harmless.
                if (cnt_next[i] == DEB_CNT) begin
                    filt[i] <= sync2[2*i +: 2];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Lane FSMs. State and the three event pulses are registered together,
    // so a pulse appears the cycle after filt shows the completing value.
    // Any filt value not listed for a state is the value that led into it
    // and simply holds the state.
    // ------------------------------------------------------------------
    state_t state [LANES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                state[i] <= S_IDLE;
            end
            lane_in  <= '0;
            lane_out <= '0;
            lane_err <= '0;
        end else begin
            // NOTE: pulses default low every cycle and are raised only on the
            // qualifying transition, which makes them exactly one cycle wide.
            lane_in  <= '0;
            lane_out <= '0;
            lane_err <= '0;
            for (int i = 0; i < LANES; i++) begin
                case (state[i])
                    S_IDLE: begin
                        case (filt[i])
                            P_OUTER: state[i] <= S_IN1;
                            P_INNER: state[i] <= S_OUT1;
                            P_BOTH: begin
                                state[i]    <= S_WAIT;
                                lane_err[i] <= 1'b1;
                            end
                            default: ;
                        endcase
                    end

                    // ---------------- entry path ----------------
                    S_IN1: begin
                        case (filt[i])
                            P_BOTH:  state[i] <= S_IN2;
                            P_NONE:  state[i] <= S_IDLE;     // abort
                            P_INNER: begin
                                state[i]    <= S_WAIT;
                                lane_err[i] <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    S_IN2: begin
                        case (filt[i])
                            P_INNER: state[i] <= S_IN3;
                            P_OUTER: state[i] <= S_IN1;      // backing off
                            P_NONE: begin
                                state[i]    <= S_IDLE;
                                lane_err[i] <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    S_IN3: begin
                        case (filt[i])
                            P_NONE: begin
                                state[i]   <= S_IDLE;
                                lane_in[i] <= 1'b1;
                            end
                            P_BOTH:  state[i] <= S_IN2;      // backing off
                            P_OUTER: begin
                                state[i]    <= S_WAIT;
                                lane_err[i] <= 1'b1;
                            end
                            default: ;
                        endcase
                    end

                    // ---------------- exit path -----------------
                    S_OUT1: begin
                        case (filt[i])
                            P_BOTH:  state[i] <= S_OUT2;
                            P_NONE:  state[i] <= S_IDLE;     // abort
                            P_OUTER: begin
                                state[i]    <= S_WAIT;
                                lane_err[i] <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    S_OUT2: begin
                        case (filt[i])
                            P_OUTER: state[i] <= S_OUT3;
                            P_INNER: state[i] <= S_OUT1;     // backing off
                            P_NONE: begin
                                state[i]    <= S_IDLE;
                                lane_err[i] <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    S_OUT3: begin
                        case (filt[i])
                            P_NONE: begin
                                state[i]    <= S_IDLE;
                                lane_out[i] <= 1'b1;
                            end
                            P_BOTH:  state[i] <= S_OUT2;     // backing off
                            P_INNER: begin
                                state[i]    <= S_WAIT;
                                lane_err[i] <= 1'b1;
                            end
                            default: ;
                        endcase
                    end

                    // Silent until the lane is clear again.
                    S_WAIT: begin
                        if (filt[i] == P_NONE) begin
                            state[i] <= S_IDLE;
                        end
                    end

                    default: state[i] <= S_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Occupancy counter. All lane pulses of one cycle are summed into a
    // signed net change first, so an entry and an exit in the same cycle
    // cancel before any clamping is considered.
    // ------------------------------------------------------------------
    logic        [NET_W-1:0] n_in;
    logic        [NET_W-1:0] n_out;
    logic signed [NET_W-1:0] net;
    logic signed [NET_W-1:0] result;

    always_comb begin
        n_in  = '0;
        n_out = '0;
        for (int i = 0; i < LANES; i++) begin
            n_in  = n_in  + NET_W'(lane_in[i]);
            n_out = n_out + NET_W'(lane_out[i]);
        end
        net    = n_in - n_out;
        result = NET_W'(occupancy) + net;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occupancy <= '0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
        end else begin
            ovf <= 1'b0;
            udf <= 1'b0;
            if (occ_load) begin
                // A load wins outright: this cycle's lane pulses are dropped.
                occupancy <= (occ_value > CAP_CNT) ? CAP_CNT : occ_value;
            end else if (result > CAP_S) begin
                occupancy <= CAP_CNT;
                ovf       <= 1'b1;
            end else if (result[NET_W-1]) begin
                occupancy <= '0;
                udf       <= 1'b1;
            end else begin
                occupancy <= result[CNT_W-1:0];
            end
        end
    end

    // Status flags follow the registered count directly.
    assign full  = (occupancy == CAP_CNT);
    assign empty = (occupancy == '0);

endmodule

// File: tb/tb_parking_lane_counter.sv
// ============================================================================
// tb_parking_lane_counter
//
// Two instances share one sensor bus: dut_a is a small lot (CAP = 3) used
// for the saturation scenarios, dut_b a large lot (CAP = 64) whose load
// input can carry a value above capacity. Every expected lane/counter event
// is pushed into a per-instance queue when the stimulus that causes it is
// driven; a negedge monitor pops one entry for each pulse it sees. Counter
// values are checked against directed constants after each scenario.
// ============================================================================
module tb_parking_lane_counter;

    localparam int LANES = 2;
    localparam int DEB   = 4;
    localparam int CAP_A = 3;
    localparam int CAP_B = 64;
    localparam int W_A   = $clog2(CAP_A + 1);
    localparam int W_B   = $clog2(CAP_B + 1);
    localparam int HOLD  = 2 * DEB;

    typedef enum int {EV_IN = 1, EV_OUT, EV_ERR, EV_OVF, EV_UDF} ev_kind_t;

    logic               clk = 1'b0;
    logic               reset;
    logic [2*LANES-1:0] sensor;
    logic               occ_load_a, occ_load_b;
    logic [W_A-1:0]     occ_value_a;
    logic [W_B-1:0]     occ_value_b;
    logic [LANES-1:0]   lane_in_v  [2];
    logic [LANES-1:0]   lane_out_v [2];
    logic [LANES-1:0]   lane_err_v [2];
    logic [W_A-1:0]     occupancy_a;
    logic [W_B-1:0]     occupancy_b;
    logic               full_v  [2];
    logic               empty_v [2];
    logic               ovf_v   [2];
    logic               udf_v   [2];

    int checks = 0;
    int errors = 0;
    int exp_a [$];
    int exp_b [$];

    always #5 clk = ~clk;

    parking_lane_counter #(.LANES(LANES), .CAP(CAP_A), .DEB(DEB)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .sensor    (sensor),
        .occ_load  (occ_load_a),
        .occ_value (occ_value_a),
        .lane_in   (lane_in_v[0]),
        .lane_out  (lane_out_v[0]),
        .lane_err  (lane_err_v[0]),
        .occupancy (occupancy_a),
        .full      (full_v[0]),
        .empty     (empty_v[0]),
        .ovf       (ovf_v[0]),
        .udf       (udf_v[0])
    );

    parking_lane_counter #(.LANES(LANES), .CAP(CAP_B), .DEB(DEB)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .sensor    (sensor),
        .occ_load  (occ_load_b),
        .occ_value (occ_value_b),
        .lane_in   (lane_in_v[1]),
        .lane_out  (lane_out_v[1]),
        .lane_err  (lane_err_v[1]),
        .occupancy (occupancy_b),
        .full      (full_v[1]),
        .empty     (empty_v[1]),
        .ovf       (ovf_v[1]),
        .udf       (udf_v[1])
    );

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ev(input ev_kind_t k, input int lane);
        return int'(k) * 16 + lane;
    endfunction

    task automatic push_both(input int code);
        exp_a.push_back(code);
        exp_b.push_back(code);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int lane, input logic [1:0] v);
        sensor[2*lane +: 2] = v;
    endtask

    task automatic step(input int lane, input logic [1:0] v, input int n);
        set_lane(lane, v);
        tick(n);
    endtask

    task automatic step2(input logic [1:0] v1, input logic [1:0] v0, input int n);
        sensor = {v1, v0};
        tick(n);
    endtask

    task automatic check_queues(input string tag);
        check({tag, " pending_a"}, exp_a.size(), 0);
        check({tag, " pending_b"}, exp_b.size(), 0);
    endtask

    // ------------------------------------------------------------------
    // Monitor: every observed pulse must match the next expected event.
    // ------------------------------------------------------------------
    task automatic observe(input int d, input int code);
        int exp;
        exp = -1;
        if (d == 0) begin
            if (exp_a.size() > 0) exp = exp_a.pop_front();
        end else begin
            if (exp_b.size() > 0) exp = exp_b.pop_front();
        end
        check((d == 0) ? "event_a" : "event_b", code, exp);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                for (int l = 0; l < LANES; l++) begin
                    if (lane_in_v[d][l])  observe(d, ev(EV_IN, l));
                    if (lane_out_v[d][l]) observe(d, ev(EV_OUT, l));
                    if (lane_err_v[d][l]) observe(d, ev(EV_ERR, l));
                end
                if (ovf_v[d]) observe(d, ev(EV_OVF, 0));
                if (udf_v[d]) observe(d, ev(EV_UDF, 0));
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int n;

        reset       = 1'b1;
        sensor      = '0;
        occ_load_a  = 1'b0;
        occ_load_b  = 1'b0;
        occ_value_a = '0;
        occ_value_b = '0;
        tick(3);

        // Reset values
        check("reset occ_a", occupancy_a, 0);
        check("reset occ_b", occupancy_b, 0);
        for (int d = 0; d < 2; d++) begin
            check("reset full",  full_v[d], 0);
            check("reset empty", empty_v[d], 1);
            check("reset ovf",   ovf_v[d], 0);
            check("reset udf",   udf_v[d], 0);
            check("reset pulses", {lane_in_v[d], lane_out_v[d], lane_err_v[d]}, 0);
        end
        reset = 1'b0;
        tick(2);

        // Single-lane entry on lane 0, with end-to-end latency measurement
        push_both(ev(EV_IN, 0));
        step(0, 2'b10, HOLD);
        step(0, 2'b11, HOLD);
        step(0, 2'b01, HOLD);
        set_lane(0, 2'b00);
        n = 0;
        while (n < 20 && occupancy_a == 0) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("entry latency", n, DEB + 4);
        tick(4);
        check_queues("entry");
        check("entry occ_a", occupancy_a, 1);
        check("entry occ_b", occupancy_b, 1);
        check("entry empty_a", empty_v[0], 0);
        check("entry full_a", full_v[0], 0);

        // Exit on lane 1 from an empty lot: underflow
        occ_load_a = 1'b1; occ_value_a = '0;
        occ_load_b = 1'b1; occ_value_b = '0;
        tick(1);
        occ_load_a = 1'b0;
        occ_load_b = 1'b0;
        check("load0 occ_a", occupancy_a, 0);
        check("load0 occ_b", occupancy_b, 0);
        push_both(ev(EV_OUT, 1));
        push_both(ev(EV_UDF, 0));
        step(1, 2'b01, HOLD);
        step(1, 2'b11, HOLD);
        step(1, 2'b10, HOLD);
        step(1, 2'b00, HOLD + 4);
        check_queues("exit udf");
        check("exit occ_a", occupancy_a, 0);
        check("exit occ_b", occupancy_b, 0);
        check("exit empty_b", empty_v[1], 1);

        // Back-off then abort: no events
        step(0, 2'b10, HOLD);
        step(0, 2'b11, HOLD);
        step(0, 2'b10, HOLD);
        step(0, 2'b00, HOLD + 4);
        check_queues("abort");

        // Back-off mid-pass then completion: one entry
        push_both(ev(EV_IN, 0));
        step(0, 2'b10, HOLD);
        step(0, 2'b11, HOLD);
        step(0, 2'b01, HOLD);
        step(0, 2'b11, HOLD);
        step(0, 2'b01, HOLD);
        step(0, 2'b00, HOLD + 4);
        check_queues("backoff");
        check("backoff occ_a", occupancy_a, 1);
        check("backoff occ_b", occupancy_b, 1);

        // Short glitch in IDLE is filtered out
        step(0, 2'b11, DEB - 1);
        step(0, 2'b00, 12);
        check_queues("glitch");
        check("glitch occ_a", occupancy_a, 1);

        // 10 -> 01 direct: error, then silent until the lane is clear
        push_both(ev(EV_ERR, 1));
        step(1, 2'b10, HOLD);
        step(1, 2'b01, HOLD);
        step(1, 2'b11, HOLD);
        step(1, 2'b10, HOLD);
        step(1, 2'b00, HOLD + 4);
        check_queues("error wait");
        check("error occ_a", occupancy_a, 1);
        check("error occ_b", occupancy_b, 1);

        // Simultaneous entries on both lanes from occupancy 2
        occ_load_a = 1'b1; occ_value_a = W_A'(2);
        occ_load_b = 1'b1; occ_value_b = W_B'(2);
        tick(1);
        occ_load_a = 1'b0;
        occ_load_b = 1'b0;
        check("load2 occ_a", occupancy_a, 2);
        push_both(ev(EV_IN, 0));
        push_both(ev(EV_IN, 1));
        exp_a.push_back(ev(EV_OVF, 0));
        step2(2'b10, 2'b10, HOLD);
        step2(2'b11, 2'b11, HOLD);
        step2(2'b01, 2'b01, HOLD);
        step2(2'b00, 2'b00, HOLD + 4);
        check_queues("dual entry");
        check("dual occ_a", occupancy_a, 3);
        check("dual full_a", full_v[0], 1);
        check("dual occ_b", occupancy_b, 4);
        check("dual full_b", full_v[1], 0);

        // One entry and one exit in the same cycle: no net change, no flag
        push_both(ev(EV_IN, 0));
        push_both(ev(EV_OUT, 1));
        step2(2'b01, 2'b10, HOLD);
        step2(2'b11, 2'b11, HOLD);
        step2(2'b10, 2'b01, HOLD);
        step2(2'b00, 2'b00, HOLD + 4);
        check_queues("in+out");
        check("in+out occ_a", occupancy_a, 3);
        check("in+out full_a", full_v[0], 1);
        check("in+out occ_b", occupancy_b, 4);

        // Load in the same cycle as an entry pulse: pulse discarded, value clamped
        push_both(ev(EV_IN, 0));
        step(0, 2'b10, HOLD);
        step(0, 2'b11, HOLD);
        step(0, 2'b01, HOLD);
        set_lane(0, 2'b00);
        tick(DEB + 3);
        check("load cycle pulse_a", lane_in_v[0][0], 1);
        check("load cycle pulse_b", lane_in_v[1][0], 1);
        occ_load_a = 1'b1; occ_value_a = '0;
        occ_load_b = 1'b1; occ_value_b = W_B'(CAP_B + 5);
        tick(1);
        occ_load_a = 1'b0;
        occ_load_b = 1'b0;
        check("load clamp occ_a", occupancy_a, 0);
        check("load clamp empty_a", empty_v[0], 1);
        check("load clamp occ_b", occupancy_b, CAP_B);
        check("load clamp full_b", full_v[1], 1);
        tick(6);
        check_queues("load");

        // Reset mid-pass, then replay the rest of the pass: no event
        step(0, 2'b10, HOLD);
        step(0, 2'b11, HOLD);
        reset = 1'b1;
        #1;
        check("async reset occ_b", occupancy_b, 0);
        check("async reset full_b", full_v[1], 0);
        check("async reset empty_a", empty_v[0], 1);
        set_lane(0, 2'b01);
        tick(3);
        reset = 1'b0;
        tick(HOLD);
        step(0, 2'b00, HOLD + 4);
        check_queues("reset replay");
        check("reset replay occ_a", occupancy_a, 0);
        check("reset replay occ_b", occupancy_b, 0);
        check("reset replay empty_b", empty_v[1], 1);
        check("reset replay ovf_b", ovf_v[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parking_lane_counter.md
# parking_lane_counter

Multi-lane parking-lot access controller. Each of `LANES` lanes has a two-beam sensor pair `{a, b}`. For every lane the block synchronises and debounces the sensor pair, classifies each complete pass as an entry or an exit, and flags invalid sequences. A shared, saturating occupancy counter with full/empty status sits behind the lanes and feeds the gate/sign logic.

## Interface
- `LANES`, default 2: number of independent sensor lanes (≥1).
- `CAP`, default 64: lot capacity, the maximum occupancy (≥1).
- `DEB`, default 4: debounce length in cycles (≥1).
- `CNT_W`: localparam, `$clog2(CAP+1)`.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `sensor`  in  2*LANES  raw beams. Lane i uses `sensor[2i+1]` = a (outer beam) and `sensor[2i]` = b (inner beam). 1 = beam blocked.
- `occ_load`  in  1  synchronous load of the occupancy counter.
- `occ_value`  in  CNT_W  load value. Values above CAP are clamped to CAP.
- `lane_in`  out  LANES  one-cycle entry pulse per lane.
- `lane_out`  out  LANES  one-cycle exit pulse per lane.
- `lane_err`  out  LANES  one-cycle invalid-sequence pulse per lane.
- `occupancy`  out  CNT_W  current car count, 0..CAP.
- `full`  out  1  high when occupancy == CAP.
- `empty`  out  1  high when occupancy == 0.
- `ovf`  out  1  one-cycle pulse: entries were clamped at CAP.
- `udf`  out  1  one-cycle pulse: exits were clamped at 0.

## Operation
- **Input conditioning, per lane:**
  - Two-flop synchroniser on the 2-bit pair, then the debouncer.
  - The debouncer tracks a candidate value and a stability counter. The filtered value `filt` takes the candidate once the synchronised value has equalled it for DEB consecutive cycles.
  - Any change in the synchronised value restarts the count.
- **Lane FSM**, clocked by `filt`. States: IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, WAIT.
  - IDLE:
    - 10 → IN1.
    - 01 → OUT1.
    - 11 → WAIT, with an error.
    - 00 → stay.
  - Entry path:
    - IN1: 11 → IN2; 00 → IDLE (abort); 01 → WAIT (error).
    - IN2: 01 → IN3; 10 → IN1 (back-off); 00 → IDLE (error).
    - IN3: 00 → IDLE, and an entry is counted; 11 → IN2 (back-off); 10 → WAIT (error).
  - Exit path mirrors the entry path with a and b swapped:
    - OUT1: 11 → OUT2; 00 → IDLE (abort); 10 → WAIT (error).
    - OUT2: 10 → OUT3; 01 → OUT1; 00 → IDLE (error).
    - OUT3: 00 → IDLE, and an exit is counted; 11 → OUT2; 01 → WAIT (error).
  - WAIT: stays until `filt` == 00, then → IDLE. No events are produced while in WAIT.
  - An unchanged `filt` holds the current state.
  - Illegal state encodings → IDLE.
- **Outputs:** `lane_in`, `lane_out` and `lane_err` are registered. Each is asserted for exactly one cycle per qualifying transition. Lanes are fully independent.
- **Occupancy update, each cycle:**
  - `net` = popcount(`lane_in`) − popcount(`lane_out`). Use a signed intermediate of width CNT_W+2 or more, wide enough for ±LANES.
  - `result` = `occupancy` + `net`.
  - If `result` > CAP: `occupancy` = CAP and `ovf` pulses.
  - If `result` < 0: `occupancy` = 0 and `udf` pulses.
  - Simultaneous entries and exits net out before clamping, so they cause no flag.
- **`occ_load`** overrides the event update in that cycle. Pulses on `lane_in`/`lane_out` in a load cycle are discarded, and no `ovf`/`udf` is raised.
- **`full` and `empty`** are derived from the registered `occupancy`.

## Timing
- **Reset values:** all FSMs IDLE; synchronisers and `filt` = 00; all pulses 0; `occupancy` = 0; `full` = 0; `empty` = 1; `ovf` = `udf` = 0.
- **Reset mid-sequence:** partial passes are lost and produce no event. Reset applies asynchronously; release is synchronous to `clk`.
- **Filter latency:** with a raw value applied before edge t and held stable, `filt` shows it after edge t+1+DEB.
- **Pulse latency:** a lane pulse is high in the cycle after `filt` presents the completing value.
- **Counter latency:**
  - `occupancy`, `full`, `empty`, `ovf` and `udf` reflect a pulse one cycle after it.
  - Raw 00 after the final step → `occupancy` change = DEB+4 edges.
- **Glitch rejection:** a raw glitch shorter than DEB cycles never reaches `filt`.
- **Throughput:** one event per lane per full pass, with no dead time beyond the filter latency.

## Test plan
- **Single-lane entry:** lane 0 steps through 10, 11, 01, 00, each held 2·DEB cycles → one `lane_in[0]` pulse, `occupancy` 0→1, `empty` falls, no `lane_err`.
- **Exit plus underflow:** lane 1 steps through 01, 11, 10, 00 with `occupancy` = 0 → `lane_out[1]` pulse, `udf` pulse, `occupancy` stays 0.
- **Back-off and abort:** 10, 11, 10, 00 → no pulses. Then 10, 11, 01, 11, 01, 00 → exactly one `lane_in`.
- **Glitch and error handling:**
  - A (DEB−1)-cycle 11 glitch during IDLE → ignored.
  - 10 → 01 direct → `lane_err` pulse, and the FSM stays in WAIT until 00.
- **Simultaneous events, LANES=2, CAP=3:**
  - Load 2. Both lanes complete entries in the same cycle → `occupancy` 3, `ovf` pulse, `full` = 1.
  - Next, one entry and one exit in the same cycle → `occupancy` stays 3, no flag.
- **Load and reset:**
  - `occ_load`=1 with `occ_value`=CAP+5 in the same cycle as a `lane_in` pulse → `occupancy` = CAP and the pulse is discarded.
  - Asserting `reset` mid-pass, then replaying the final steps → all outputs at reset values and no event.
